serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fulladder.sv | 13 +
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared adder definitions: FSM state encodings and the default operand width.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [1:0] StIdleEnc = 2'd0;
  localparam logic [1:0] StRunEnc  = 2'd1;
  localparam logic [1:0] StDoneEnc = 2'd2;

  typedef enum logic [1:0] {
    StIdle = StIdleEnc,
    StRun  = StRunEnc,
    StDone = StDoneEnc
  } state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the per-bit datapath of the serial adder.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder processes operands LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_cin,
  output logic [WIDTH-1:0] o_w_s,
  output logic             o_w_cout,
  output logic             o_w_busy,
  output logic             o_w_done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d, s_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_cout;

  fulladder u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
  assign sum_d = {fa_s, sum_q[WIDTH-1:1]};

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (i_w_start) begin
            a_q     <= i_w_a;
            b_q     <= i_w_b;
            sum_q   <= '0;
            carry_q <= i_w_cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_cout;
          if (cnt_q == LastBit) begin
            s_q     <= sum_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_w_s    = s_q;
  assign o_w_cout = cout_q;
  assign o_w_busy = busy_q;
  assign o_w_done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner sequences, random scoreboard.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] o_s;
  logic         o_cout, o_busy, o_done;

  int checks = 0;
  int errors = 0;
  logic done_seen;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  serial_adder #(.WIDTH(W)) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .i_w_start (start),
    .i_w_a     (a),
    .i_w_b     (b),
    .i_w_cin   (cin),
    .o_w_s     (o_s),
    .o_w_cout  (o_cout),
    .o_w_busy  (o_busy),
    .o_w_done  (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs sampled on the following falling edge.
  task automatic step();
    logic [W:0] e;
    @(posedge clk);
    @(negedge clk);
    done_seen = o_done;
    if (o_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(o_s), 32'(e[W-1:0]));
        chk("cout", 32'(o_cout), 32'(e[W]));
      end
    end
  endtask

  task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                             input logic [W:0] exp_res);
    start = 1'b1;
    a = ia;
    b = ib;
    cin = ic;
    exp_q.push_back(exp_res);
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < int'(W) + 4) begin
      step();
      n++;
    end
    if (!done_seen) chk("done_timeout", 32'(done_seen), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           gap;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, cout: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, cout: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, cout: 1'b1};
    vecs[6] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, cout: 1'b1};
    vecs[7] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, cout: 1'b0};

    rst = 1'b1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    done_seen = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("reset_s", 32'(o_s), 32'd0);
    chk("reset_cout", 32'(o_cout), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    step();

    // Exact latency: busy after E0..E7, done only after E8.
    drive_start(8'h0F, 8'h01, 1'b0, 9'h010);
    for (int k = 0; k < 7; k++) begin
      chk("busy_run", 32'(o_busy), 32'd1);
      chk("done_early", 32'(o_done), 32'd0);
      step();
    end
    chk("busy_e7", 32'(o_busy), 32'd1);
    step();
    chk("done_e8", 32'(o_done), 32'd1);
    chk("busy_e8", 32'(o_busy), 32'd0);
    step();
    chk("done_e9", 32'(o_done), 32'd0);
    step();
    step();
    chk("hold_idle_s", 32'(o_s), 32'h10);

    for (int i = 0; i < 8; i++) begin
      drive_start(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].s});
      wait_done();
      step();
    end

    // Start during RUN is ignored.
    drive_start(8'h12, 8'h34, 1'b0, 9'h046);
    step();
    step();
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    step();
    start = 1'b0;
    for (int k = 4; k <= 8; k++) step();
    chk("ignored_start_done_e8", 32'(done_seen), 32'd1);
    step();
    chk("no_second_done", 32'(o_done), 32'd0);

    // Back-to-back start during DONE.
    drive_start(8'h01, 8'h01, 1'b0, 9'h002);
    wait_done();
    chk("first_done_s", 32'(o_s), 32'h02);
    drive_start(8'h20, 8'h03, 1'b0, 9'h023);
    chk("b2b_busy", 32'(o_busy), 32'd1);
    chk("hold_run_s", 32'(o_s), 32'h02);
    for (int k = 1; k < 8; k++) step();
    chk("b2b_not_yet", 32'(done_seen), 32'd0);
    step();
    chk("b2b_done_8_edges", 32'(done_seen), 32'd1);
    step();

    // Reset mid-operation abandons the addition.
    drive_start(8'hAA, 8'h55, 1'b0, 9'h0FF);
    step();
    step();
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    exp_q.delete();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_run_s", 32'(o_s), 32'd0);
    chk("rst_run_cout", 32'(o_cout), 32'd0);
    chk("rst_run_busy", 32'(o_busy), 32'd0);
    chk("rst_run_done", 32'(o_done), 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_no_done", 32'(o_done), 32'd0);
    end
    drive_start(8'h01, 8'h02, 1'b0, 9'h003);
    wait_done();
    chk("after_rst_s", 32'(o_s), 32'h03);
    step();

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      drive_start(ra, rb, rc, (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc));
      wait_done();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
